// File: rtl/snpu_rnd_sched.sv
// snpu_rnd_sched: freeze/address sequencer for the SNPU ring-oscillator RNG bank.
// Optional macro SNPU_SCHED_ROTFOLD_EN: fold mode rotates the accumulator left by one before each XOR.
module snpu_rnd_sched #(
    parameter int RND_N   = 48,
    parameter int ADDR_W  = 6,
    parameter int SETTLE  = 4,
    parameter int RUN_MIN = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              bank_freeze,
    output logic [ADDR_W-1:0] bank_addr,
    input  logic [15:0]       bank_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_fold,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_err
);

    // state | meaning
    // COOL  | bank free-running; timer counts down the minimum run time
    // IDLE  | waiting for a command (only offered while no result is pending)
    // HOLD  | bank frozen on bank_addr; timer counts settle time, capture at terminal count
    // DONE  | release freeze, publish accumulator, start the run timer

    typedef enum logic [1:0] {COOL, IDLE, HOLD, DONE} state_t;

    localparam int CNT_MAX = (RUN_MIN > SETTLE) ? RUN_MIN : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  RUN_LOAD    = CNT_W'(RUN_MIN);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0]  TMR_ONE     = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(RND_N - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   RND_N_EXT   = (ADDR_W + 1)'(RND_N);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  tmr;
    logic [CNT_W-1:0]  tmr_nxt;
    logic [15:0]       acc;
    logic [15:0]       acc_nxt;
    logic [15:0]       acc_step;
    logic              fold_q;
    logic              fold_nxt;
    logic              freeze_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              out_valid_nxt;
    logic [15:0]       out_data_nxt;
    logic              out_err_nxt;
    logic              tmr_tc;
    logic              addr_bad;
    logic              at_last_addr;
    logic              cmd_take;

    assign cmd_ready    = (state == IDLE) && !out_valid;
    assign cmd_take     = cmd_valid && cmd_ready;
    assign tmr_tc       = (tmr == TMR_ONE);
    assign addr_bad     = ({1'b0, cmd_addr} >= RND_N_EXT);
    assign at_last_addr = (bank_addr == LAST_ADDR);

`ifdef SNPU_SCHED_ROTFOLD_EN
    assign acc_step = fold_q ? ({acc[14:0], acc[15]} ^ bank_data) : (acc ^ bank_data);
`else
    assign acc_step = acc ^ bank_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COOL;
            tmr         <= RUN_LOAD;
            acc         <= '0;
            fold_q      <= 1'b0;
            bank_freeze <= 1'b0;
            bank_addr   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            acc         <= acc_nxt;
            fold_q      <= fold_nxt;
            bank_freeze <= freeze_nxt;
            bank_addr   <= addr_nxt;
            out_valid   <= out_valid_nxt;
            out_data    <= out_data_nxt;
            out_err     <= out_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tmr_nxt       = tmr;
        acc_nxt       = acc;
        fold_nxt      = fold_q;
        freeze_nxt    = bank_freeze;
        addr_nxt      = bank_addr;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_err_nxt   = out_err;

        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        case (state)
            COOL: begin
                tmr_nxt = tmr - TMR_ONE;
                if (tmr_tc) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (cmd_take) begin
                    if (!cmd_fold && addr_bad) begin
                        // Rejected single sample: report at once, bank never frozen, no cool-down.
                        out_valid_nxt = 1'b1;
                        out_err_nxt   = 1'b1;
                        out_data_nxt  = '0;
                    end else begin
                        fold_nxt   = cmd_fold;
                        addr_nxt   = cmd_fold ? '0 : cmd_addr;
                        acc_nxt    = '0;
                        freeze_nxt = 1'b1;
                        tmr_nxt    = SETTLE_LOAD;
                        state_nxt  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tmr_tc) begin
                    acc_nxt = acc_step;
                    if (!fold_q || at_last_addr) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt = bank_addr + ADDR_ONE;
                        tmr_nxt  = SETTLE_LOAD;
                    end
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            DONE: begin
                freeze_nxt    = 1'b0;
                addr_nxt      = '0;
                out_valid_nxt = 1'b1;
                out_data_nxt  = acc;
                out_err_nxt   = 1'b0;
                tmr_nxt       = RUN_LOAD;
                state_nxt     = COOL;
            end
            default: begin
                state_nxt = COOL;
                tmr_nxt   = RUN_LOAD;
            end
        endcase
    end

endmodule
